atom_spi_master: RTL and testbench
==================================

# atom_spi_master

SPI mode-0 initiator that moves single bytes between the Atom core's MMC interface and the SD path. It drives `sdclk`, `sdmosi` and `sdss`, and samples `sdmiso`. In the top level its outputs feed the real-card pins and the virtual `sd_card` responder through the existing `vsd_sel` steering. It also offers an optional activity output for the disk LED.

## Interface
Parameters:
- `FAST_DIV`, default 0: SCK half-period is `FAST_DIV+1` clk_sys cycles when `slow`=0.
- `SLOW_DIV`, default 63: SCK half-period is `SLOW_DIV+1` clk_sys cycles when `slow`=1 (card init).
- `ACT_TIMEOUT`, default 2000000: activity hold time in clk_sys cycles.

Ports:
- `clk_sys` in 1: single clock; every register is on its rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `start` in 1: request a byte transfer; accepted only when `busy`=0.
- `tx_data` in 8: byte to send, MSB first; captured when `start` is accepted.
- `slow` in 1: divider select; captured when `start` is accepted.
- `cs_n_in` in 1: requested chip-select level; applied only while `busy`=0.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse when `rx_data` is valid.
- `rx_data` out 8: received byte.
- `sclk` out 1: SPI clock (CPOL=0).
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.
- `ss` out 1: chip select, active-low.
- `act` out 1: SD activity indicator.

## Operation
- States:
  - IDLE: `sclk`=0, `mosi`=1, `busy`=0.
  - LOW: SCK low half.
  - HIGH: SCK high half.
- IDLE -> LOW on `start`:
  - load the shift register with `tx_data`.
  - latch `div` = `slow` ? `SLOW_DIV` : `FAST_DIV`.
  - set bit counter to 7.
  - drive `mosi` = `tx_data[7]`.
- LOW -> HIGH when the half-period counter reaches `div`:
  - `sclk` goes to 1.
  - `miso` is shifted into the rx shift register LSB on the same edge.
- HIGH -> LOW when the half-period counter reaches `div` and bit counter > 0:
  - `sclk` goes to 0.
  - `mosi` takes the next bit.
  - bit counter decrements.
- HIGH -> IDLE when the half-period counter reaches `div` and bit counter = 0:
  - `sclk` goes to 0 and `mosi` goes to 1.
  - `rx_data` updates and `done` pulses.
- The half-period counter is 8 bits. It clears on every state change.
- `start` while `busy`=1 is ignored; there is no queue.
- Changes to `tx_data`/`slow` during a transfer have no effect.
- `ss` follows `cs_n_in` with one cycle of register delay, but only while `busy`=0. While busy it holds its value; a pending change applies the cycle after `busy` falls.
- `start` and a `cs_n_in` change in the same IDLE cycle: both take effect in that cycle.

## Timing
- Reset values: `sclk`=0, `mosi`=1, `ss`=1, `busy`=0, `done`=0, `rx_data`=0x00, `act`=0. The state goes to IDLE.
- Reset mid-transfer aborts immediately. No `done` is produced and the partial rx byte is discarded.
- Let T = `div`+1. With `start` accepted at cycle t0:
  - t0+1: `busy`=1, `mosi`=bit7.
  - `sclk` rises at t0+1+(2k+1)T for k=0..7.
  - `done`=1 and `busy`=0 at t0+1+16T.
- Back-to-back: the earliest next accept is the cycle `done` is high. Byte rate is 16T+1 cycles.
- `miso` is sampled unsynchronised (same clock domain as the responder).

## Configuration
- `ATOM_SPI_ACT_EN` defined:
  - instantiate the activity timer. A 22-bit saturating counter clears to 0 on any toggle of `mosi` or `miso` (compared to previous-cycle values).
  - otherwise it increments while < `ACT_TIMEOUT`.
  - `act` = counter < `ACT_TIMEOUT`.
  - reset loads `ACT_TIMEOUT`, so `act`=0.
- Not defined: `act` is tied to 0 and no counter exists.

## Structure
- Package `atom_spi_pkg`:
  - state enum `spi_state_t` {IDLE, LOW, HIGH}.
  - default divider constants.
  - `ACT_W`=22.
- Sub-module `atom_spi_act`: the activity timer, instantiated only under `ATOM_SPI_ACT_EN`.
- The transfer FSM, shift registers and divider stay in `atom_spi_master`.

## Test plan
- Loopback (`miso`=`mosi`), `FAST_DIV`=0, `tx_data`=0xA5, `start` at t0 -> `done` at t0+17, `rx_data`=0xA5. The `mosi` bit sequence is 1,0,1,0,0,1,0,1 on the rising edges.
- `slow`=1, `SLOW_DIV`=3, `miso` tied 1, `tx_data`=0xFF -> `sclk` high 4 cycles and low 4 cycles, 8 rising edges, `done` at t0+65, `rx_data`=0xFF.
- `start` pulsed again at t0+5 with `tx_data`=0x00 during a 0x3C transfer -> ignored. Exactly one `done`, and the `mosi` stream matches 0x3C.
- `cs_n_in` dropped to 0 at t0+3 during a transfer -> `ss` stays 1 until `busy` falls, then 0 the next cycle. In IDLE a change shows on `ss` after 1 cycle.
- `reset_n`=0 at t0+6 mid-transfer -> next cycle `sclk`=0, `mosi`=1, `ss`=1, `busy`=0, `rx_data`=0x00, no `done`.
- With `ATOM_SPI_ACT_EN`, `ACT_TIMEOUT`=10 -> `act`=0 after reset, rises the cycle after the first `mosi` toggle, and falls 10 cycles after the last toggle. Without the macro, `act` stays 0 throughout.

Source files
------------

// File: rtl/atom_spi_pkg.sv
// Shared types and constants for the Atom MMC SPI master and its activity timer.
package atom_spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } spi_state_t;

   localparam int DIV_W           = 8;
   localparam int FAST_DIV_DEF    = 0;
   localparam int SLOW_DIV_DEF    = 63;
   localparam int ACT_TIMEOUT_DEF = 2000000;
   localparam int ACT_W           = 22;

endpackage

// File: rtl/atom_spi_act.sv
// SD activity timer: act is high until ACT_TIMEOUT cycles pass with no mosi/miso toggle.
module atom_spi_act
   import atom_spi_pkg::*;
#(
   parameter int ACT_TIMEOUT = ACT_TIMEOUT_DEF
) (
   input  logic clk_sys_i,
   input  logic reset_n_i,
   input  logic mosi_i,
   input  logic miso_i,
   output logic act_o
);

   localparam logic [ACT_W-1:0] TIMEOUT = ACT_W'(ACT_TIMEOUT);

   logic [ACT_W-1:0] cnt_q, cnt_d;
   logic             mosi_q, miso_q;

   always_comb begin
      cnt_d = cnt_q;
      if ((mosi_i != mosi_q) || (miso_i != miso_q)) begin
         cnt_d = '0;
      end else if (cnt_q < TIMEOUT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Previous-cycle line values are captured even in reset so the first
   // post-reset cycle compares against real levels.
   always_ff @(posedge clk_sys_i) begin
      mosi_q <= mosi_i;
      miso_q <= miso_i;
      if (!reset_n_i) begin
         cnt_q <= TIMEOUT;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign act_o = (cnt_q < TIMEOUT);

endmodule

// File: rtl/atom_spi_master.sv
// SPI mode-0 byte initiator for the Atom MMC path (sclk/mosi/ss out, miso in).
// Optional disk-LED activity timer is built when ATOM_SPI_ACT_EN is defined.
//
//   state | meaning
//   IDLE  | no transfer, sclk=0, mosi=1, ss follows cs_n_in
//   LOW   | SCK low half-period, mosi holds current bit
//   HIGH  | SCK high half-period, miso bit already captured
module atom_spi_master
   import atom_spi_pkg::*;
#(
   parameter int FAST_DIV    = FAST_DIV_DEF,
   parameter int SLOW_DIV    = SLOW_DIV_DEF,
   parameter int ACT_TIMEOUT = ACT_TIMEOUT_DEF
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] tx_data,
   input  logic       slow,
   input  logic       cs_n_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       ss,
   output logic       act
);

   localparam logic [DIV_W-1:0] FAST_DIV_C = DIV_W'(FAST_DIV);
   localparam logic [DIV_W-1:0] SLOW_DIV_C = DIV_W'(SLOW_DIV);

   spi_state_t       state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [6:0]       tx_rem_q, tx_rem_d;
   logic [7:0]       rx_sh_q, rx_sh_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic [2:0]       bit_q, bit_d;
   logic             mosi_q, mosi_d;
   logic             sclk_q, sclk_d;
   logic             done_q, done_d;
   logic             ss_q, ss_d;
   logic             half_end;

   assign half_end = (cnt_q == div_q);

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         div_q     <= '0;
         tx_rem_q  <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         bit_q     <= '0;
         mosi_q    <= 1'b1;
         sclk_q    <= 1'b0;
         done_q    <= 1'b0;
         ss_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         tx_rem_q  <= tx_rem_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         bit_q     <= bit_d;
         mosi_q    <= mosi_d;
         sclk_q    <= sclk_d;
         done_q    <= done_d;
         ss_q      <= ss_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = LOW;
         LOW:     if (half_end) state_d = HIGH;
         HIGH:    if (half_end) state_d = (bit_q == 3'd0) ? IDLE : LOW;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = ((state_d != state_q) || (state_q == IDLE)) ? '0 : cnt_q + 1'b1;
      div_d     = div_q;
      tx_rem_d  = tx_rem_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      bit_d     = bit_q;
      mosi_d    = mosi_q;
      sclk_d    = (state_d == HIGH);
      done_d    = 1'b0;
      // ss is frozen for the whole byte so the card never sees a mid-byte deselect.
      ss_d      = (state_q == IDLE) ? cs_n_in : ss_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               tx_rem_d = tx_data[6:0];
               div_d    = slow ? SLOW_DIV_C : FAST_DIV_C;
               bit_d    = 3'd7;
               mosi_d   = tx_data[7];
            end
         end
         LOW: begin
            if (half_end) rx_sh_d = {rx_sh_q[6:0], miso};
         end
         HIGH: begin
            if (half_end) begin
               if (bit_q == 3'd0) begin
                  mosi_d    = 1'b1;
                  rx_data_d = rx_sh_q;
                  done_d    = 1'b1;
               end else begin
                  mosi_d   = tx_rem_q[6];
                  tx_rem_d = {tx_rem_q[5:0], 1'b0};
                  bit_d    = bit_q - 3'd1;
               end
            end
         end
         default: ;
      endcase
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign ss      = ss_q;

`ifdef ATOM_SPI_ACT_EN
   atom_spi_act #(
      .ACT_TIMEOUT (ACT_TIMEOUT)
   ) u_act (
      .clk_sys_i (clk_sys),
      .reset_n_i (reset_n),
      .mosi_i    (mosi_q),
      .miso_i    (miso),
      .act_o     (act)
   );
`else
   assign act = 1'b0;
`endif

endmodule

// File: tb/tb_atom_spi_master.sv
// Scoreboard bench for atom_spi_master: stimulus pushes expected bytes/timing,
// a negedge monitor pops and checks on every done pulse.
module tb_atom_spi_master;

   localparam int FAST = 0;
   localparam int SLOW = 3;
   localparam int ACT_TO = 10;

   logic       clk_sys = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       slow = 1'b0;
   logic       cs_n_in = 1'b1;
   logic       busy, done, sclk, mosi, miso, ss, act;
   logic [7:0] rx_data;
   logic       lb = 1'b0;
   logic       miso_drv = 1'b0;

   assign miso = lb ? mosi : miso_drv;

   atom_spi_master #(.FAST_DIV(FAST), .SLOW_DIV(SLOW), .ACT_TIMEOUT(ACT_TO)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .tx_data(tx_data),
      .slow(slow), .cs_n_in(cs_n_in), .busy(busy), .done(done), .rx_data(rx_data),
      .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss), .act(act));

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] rx;
      int         t0;
      int         tp;
      logic       lb;
      logic [7:0] m;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   last_rst = 0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_xfer(input logic [7:0] tx, input logic sl, input logic lbm,
                          input logic [7:0] m, input logic cs);
      int k = 0;
      while (busy !== 1'b0 && k < 3000) begin
         step();
         k++;
      end
      if (busy !== 1'b0) begin
         chk("accept_timeout", 32'(busy), 32'd0);
         return;
      end
      start = 1'b1; tx_data = tx; slow = sl; cs_n_in = cs; lb = lbm; miso_drv = m[7];
      q.push_back('{tx: tx, rx: (lbm ? tx : m), t0: cyc,
                    tp: (sl ? SLOW + 1 : FAST + 1), lb: lbm, m: m});
      step();
      start = 1'b0; tx_data = 8'($urandom); slow = 1'($urandom);
      chk("busy_t0p1", 32'(busy), 32'd1);
      chk("mosi_t0p1", 32'(mosi), 32'(tx[7]));
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 3000) begin
         step();
         k++;
      end
      if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   // Monitor / responder state
   logic       sclk_prev = 1'b0;
   logic       mosi_prev = 1'b1;
   logic       miso_prev = 1'b0;
   int         nrise = 0, nfall = 0, last_tog = -100;
   logic       rise_ok = 1'b1;
   logic [7:0] mosi_acc = 8'h00;

   always @(negedge clk_sys) begin
      logic exp_act;
      exp_t e;
      if (sclk && !sclk_prev) begin
         if (q.size() > 0 && cyc != q[0].t0 + 1 + (2 * nrise + 1) * q[0].tp) rise_ok = 1'b0;
         mosi_acc = {mosi_acc[6:0], mosi};
         nrise++;
      end
      if (!sclk && sclk_prev) begin
         nfall++;
         if (q.size() > 0 && !q[0].lb && nfall <= 7) miso_drv = q[0].m[7 - nfall];
      end
      if (done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("rx_data", 32'(rx_data), 32'(e.rx));
            chk("done_cycle", 32'(cyc), 32'(e.t0 + 1 + 16 * e.tp));
            chk("mosi_stream", 32'(mosi_acc), 32'(e.tx));
            chk("sclk_rises", 32'(nrise), 32'd8);
            chk("sclk_timing", 32'(rise_ok), 32'd1);
         end
      end
      if (!busy) begin
         chk("idle_lines", {30'd0, sclk, mosi}, 32'd1);
         nrise = 0; nfall = 0; rise_ok = 1'b1;
      end
`ifdef ATOM_SPI_ACT_EN
      exp_act = (cyc - last_tog >= 1) && (cyc - last_tog <= ACT_TO) &&
                !(last_rst >= last_tog && last_rst < cyc);
`else
      exp_act = 1'b0;
`endif
      chk("act", 32'(act), 32'(exp_act));
      if (mosi !== mosi_prev || miso !== miso_prev) last_tog = cyc;
      mosi_prev = mosi;
      miso_prev = miso;
      sclk_prev = sclk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      repeat (3) step();
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_mosi", 32'(mosi), 32'd1);
      chk("rst_ss", 32'(ss), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rx", 32'(rx_data), 32'd0);
      chk("rst_act", 32'(act), 32'd0);
      reset_n = 1'b1;
      last_rst = cyc - 1;
      repeat (2) step();

      // Loopback 0xA5 fast, then slow 0xFF with miso held high.
      do_xfer(8'hA5, 1'b0, 1'b1, 8'h00, 1'b1);
      drain();
      do_xfer(8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
      drain();

      // Second start during a 0x3C transfer must be ignored.
      do_xfer(8'h3C, 1'b0, 1'b1, 8'h00, 1'b1);
      repeat (4) step();
      start = 1'b1; tx_data = 8'h00;
      step();
      start = 1'b0;
      drain();
      repeat (3) step();

      // Chip select frozen while busy, applied the cycle after busy falls.
      do_xfer(8'h96, 1'b0, 1'b0, 8'h5B, 1'b1);
      repeat (2) step();
      cs_n_in = 1'b0;
      for (int k = 0; k < 40 && busy; k++) begin
         chk("ss_hold_busy", 32'(ss), 32'd1);
         step();
      end
      chk("ss_at_busy_fall", 32'(ss), 32'd1);
      step();
      chk("ss_after_busy", 32'(ss), 32'd0);
      repeat (2) step();

      // start and cs change together in an idle cycle.
      do_xfer(8'h0F, 1'b0, 1'b1, 8'h00, 1'b1);
      chk("ss_with_start", 32'(ss), 32'd1);
      drain();
      step();
      cs_n_in = 1'b0;
      chk("ss_idle_before", 32'(ss), 32'd1);
      step();
      chk("ss_idle_after", 32'(ss), 32'd0);

      // Reset in the middle of a transfer.
      do_xfer(8'h5A, 1'b0, 1'b0, 8'hC3, 1'b0);
      t0 = cyc - 1;
      repeat (5) step();
      reset_n = 1'b0;
      q.delete();
      step();
      chk("mid_rst_cycle", 32'(cyc), 32'(t0 + 7));
      chk("mid_rst_sclk", 32'(sclk), 32'd0);
      chk("mid_rst_mosi", 32'(mosi), 32'd1);
      chk("mid_rst_ss", 32'(ss), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_rx", 32'(rx_data), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      reset_n = 1'b1;
      last_rst = cyc - 1;
      step();
      chk("ss_after_rst", 32'(ss), 32'd0);
      repeat (30) step();

      // Randomized transfers, including back-to-back starts in the done cycle.
      for (int i = 0; i < 24; i++) begin
         repeat ($urandom_range(0, 2)) step();
         do_xfer(8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom), 1'b0);
      end
      drain();
      repeat (20) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
